// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode/operand-fetch stage: opcodes, immediate formats,
// FSM encoding, ID/EX payload layout and the pure decode/forwarding helpers.
package id_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic            RstEnable = 1'b1;
    localparam logic            Writeable = 1'b1;
    localparam logic            Readable  = 1'b1;
    localparam logic [XLEN-1:0] ZeroWorld = '0;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } dec_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic              wen;
    } idex_t;

    // Register usage per opcode; unknown opcodes decode as a NOP touching nothing.
    function automatic dec_t decode(input logic [6:0] opcode);
        dec_t d;
        d.uses_rs1  = 1'b0;
        d.uses_rs2  = 1'b0;
        d.writes_rd = 1'b0;
        case (opcode)
            OP_R: begin
                d.uses_rs1  = Readable;
                d.uses_rs2  = Readable;
                d.writes_rd = Writeable;
            end
            OP_STORE, OP_BRANCH: begin
                d.uses_rs1 = Readable;
                d.uses_rs2 = Readable;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                d.uses_rs1  = Readable;
                d.writes_rd = Writeable;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                d.writes_rd = Writeable;
            end
            default: begin
                d.uses_rs1  = 1'b0;
                d.uses_rs2  = 1'b0;
                d.writes_rd = 1'b0;
            end
        endcase
        return d;
    endfunction

    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // A load in EX is never forwarded: its data only exists once it reaches MEM.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data,
        input logic              ex_fwd,
        input logic [REG_AW-1:0] ex_waddr,
        input logic [XLEN-1:0]   ex_wdata,
        input logic              mem_wen,
        input logic [REG_AW-1:0] mem_waddr,
        input logic [XLEN-1:0]   mem_wdata
    );
        if (rs == '0) begin
            return ZeroWorld;
        end else if (ex_fwd && (ex_waddr == rs)) begin
            return ex_wdata;
        end else if (mem_wen && (mem_waddr == rs)) begin
            return mem_wdata;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/id_operand_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate of an RV32I
// encoding; formats without an immediate yield zero.
module id_operand_stage_imm_gen
    import id_operand_stage_pkg::*;
(
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] imm_o
);

    imm_fmt_e fmt;

    assign fmt = imm_format(inst_i[6:0]);

    always_comb begin
        // NOTE: the default assignment up front keeps this block free of inferred latches.
        imm_o = ZeroWorld;
        case (fmt)
            IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            IMM_U: imm_o = {inst_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            default: imm_o = ZeroWorld;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: drives the register file read ports, forwards EX/MEM
// results, inserts one bubble on load-use and owns the ID/EX pipeline register.
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_inst,
    output logic              id_ready,

    output logic              read1_or_not,
    output logic              read2_or_not,
    output logic [REG_AW-1:0] readaddr1,
    output logic [REG_AW-1:0] readaddr2,
    input  logic [XLEN-1:0]   read1data,
    input  logic [XLEN-1:0]   read2data,

    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [XLEN-1:0]   ex_wdata,

    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,

    input  logic              flush_in,
    input  logic              ex_ready,

    output logic              idex_valid,
    output logic [XLEN-1:0]   idex_pc,
    output logic [XLEN-1:0]   idex_inst,
    output logic [XLEN-1:0]   idex_rs1_val,
    output logic [XLEN-1:0]   idex_rs2_val,
    output logic [XLEN-1:0]   idex_imm,
    output logic [REG_AW-1:0] idex_rd,
    output logic              idex_wen
);

    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [REG_AW-1:0] rd_idx;
    dec_t              dec;
    logic [XLEN-1:0]   imm;

    logic              ex_fwd;
    logic              load_in_ex;
    logic              hazard;
    logic              accept;

    state_e            state_q;
    logic              idex_valid_q;
    idex_t             idex_d;
    idex_t             idex_q;

    assign rs1_idx = if_inst[19:15];
    assign rs2_idx = if_inst[24:20];
    assign rd_idx  = if_inst[11:7];
    assign dec     = decode(if_inst[6:0]);

    id_operand_stage_imm_gen u_imm_gen (
        .inst_i (if_inst),
        .imm_o  (imm)
    );

    assign readaddr1    = rs1_idx;
    assign readaddr2    = rs2_idx;
    assign read1_or_not = (rst_in != RstEnable) && if_valid && dec.uses_rs1;
    assign read2_or_not = (rst_in != RstEnable) && if_valid && dec.uses_rs2;

    assign ex_fwd     = ex_valid && ex_wen && !ex_is_load;
    assign load_in_ex = ex_valid && ex_is_load && ex_wen && (ex_waddr != '0);
    assign hazard     = if_valid && load_in_ex &&
                        ((dec.uses_rs1 && (ex_waddr == rs1_idx)) ||
                         (dec.uses_rs2 && (ex_waddr == rs2_idx)));

    // In STALL the load has moved on to MEM, so the instruction is taken without a re-check.
    assign accept = (state_q == ST_STALL) || !hazard;

    always_comb begin
        idex_d         = '0;
        idex_d.pc      = if_pc;
        idex_d.inst    = if_inst;
        idex_d.rs1_val = select_operand(rs1_idx, read1data, ex_fwd, ex_waddr, ex_wdata,
                                        mem_wen, mem_waddr, mem_wdata);
        idex_d.rs2_val = select_operand(rs2_idx, read2data, ex_fwd, ex_waddr, ex_wdata,
                                        mem_wen, mem_waddr, mem_wdata);
        idex_d.imm     = imm;
        idex_d.rd      = rd_idx;
        idex_d.wen     = dec.writes_rd && (rd_idx != '0);
    end

    always_comb begin
        id_ready = 1'b1;
        if (flush_in) begin
            id_ready = 1'b1;
        end else if (!ex_ready) begin
            id_ready = 1'b0;
        end else if (!accept) begin
            id_ready = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst_in == RstEnable) begin
            state_q      <= ST_RUN;
            idex_valid_q <= 1'b0;
            idex_q       <= '0;
        end else if (flush_in) begin
            state_q      <= ST_RUN;
            idex_valid_q <= 1'b0;
        end else if (ex_ready) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        idex_valid_q <= 1'b0;
                        state_q      <= ST_STALL;
                    end else begin
                        idex_valid_q <= if_valid;
                        if (if_valid) begin
                            idex_q <= idex_d;
                        end
                    end
                end
                ST_STALL: begin
                    idex_valid_q <= if_valid;
                    if (if_valid) begin
                        idex_q <= idex_d;
                    end
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign idex_valid   = idex_valid_q;
    assign idex_pc      = idex_q.pc;
    assign idex_inst    = idex_q.inst;
    assign idex_rs1_val = idex_q.rs1_val;
    assign idex_rs2_val = idex_q.rs2_val;
    assign idex_imm     = idex_q.imm;
    assign idex_rd      = idex_q.rd;
    assign idex_wen     = idex_q.wen;

endmodule
